// File: rtl/rll_key_pkg.sv
// Shared types and defaults for the RLL key sequencer and related locked-core wrappers.
package rll_key_pkg;

  localparam int unsigned DEF_KEY_WIDTH  = 32;
  localparam int unsigned DEF_WORD_WIDTH = 8;
  localparam int unsigned DEF_OUT_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETTLE = 3'd2,
    ACTIVE = 3'd3,
    ERROR  = 3'd4
  } state_t;

  function automatic int unsigned nwords(input int unsigned key_w, input int unsigned word_w);
    return key_w / word_w;
  endfunction

endpackage

// File: rtl/rll_out_gate.sv
// Parametric AND-mask of a locked core's primary outputs by an enable.
module rll_out_gate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = din & {WIDTH{en}};

endmodule

// File: rtl/rll_key_sequencer.sv
// Word-serial key loader for a random-logic-locked core with atomic key apply and output unmask.
// Optional even-parity check on key words when KEY_PARITY_CHECK_EN is defined.
module rll_key_sequencer
  import rll_key_pkg::*;
#(
  parameter int unsigned KEY_WIDTH     = DEF_KEY_WIDTH,
  parameter int unsigned WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int unsigned OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  relock,
  input  logic                  kw_valid,
  input  logic [WORD_WIDTH-1:0] kw_data,
  input  logic                  kw_last,
`ifdef KEY_PARITY_CHECK_EN
  input  logic                  kw_parity,
`endif
  output logic                  kw_ready,
  output logic [KEY_WIDTH-1:0]  key_out,
  input  logic [OUT_WIDTH-1:0]  core_out_in,
  output logic [OUT_WIDTH-1:0]  core_out_gated,
  output logic                  key_loaded,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned NWORDS = nwords(KEY_WIDTH, WORD_WIDTH);
  localparam int unsigned CNT_W  = $clog2(NWORDS) + 1;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES) + 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;

  logic                 handshake;
  logic                 last_word;
  logic                 proto_err;
  logic [KEY_WIDTH-1:0] shadow_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      shadow_q <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
    end
  end

  // Shadow with the incoming word merged at the current word slot.
  always_comb begin
    shadow_nxt = shadow_q;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        shadow_nxt[i*WORD_WIDTH +: WORD_WIDTH] = kw_data;
      end
    end
  end

  assign handshake = kw_valid && (state_q == FETCH);
  assign last_word = (cnt_q == CNT_W'(NWORDS - 1));

`ifdef KEY_PARITY_CHECK_EN
  assign proto_err = (kw_last != last_word) || (kw_parity != (^kw_data));
`else
  assign proto_err = (kw_last != last_word);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    key_d    = key_q;

    unique case (state_q)
      IDLE, ACTIVE, ERROR: begin
        if (start) begin
          state_d  = FETCH;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      FETCH: begin
        if (handshake) begin
          if (proto_err) begin
            state_d  = ERROR;
            cnt_d    = '0;
            shadow_d = '0;
            key_d    = '0;
          end else if (last_word) begin
            // Whole key reaches the core on a single edge.
            state_d  = SETTLE;
            shadow_d = shadow_nxt;
            key_d    = shadow_nxt;
            settle_d = SET_W'(SETTLE_CYCLES - 1);
          end else begin
            shadow_d = shadow_nxt;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = ACTIVE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Relock overrides everything, including an in-flight handshake.
    if (relock) begin
      state_d  = IDLE;
      cnt_d    = '0;
      settle_d = '0;
      shadow_d = '0;
      key_d    = '0;
    end
  end

  assign kw_ready   = (state_q == FETCH);
  assign busy       = (state_q == FETCH) || (state_q == SETTLE);
  assign key_loaded = (state_q == ACTIVE);
  assign err        = (state_q == ERROR);
  assign key_out    = key_q;

  rll_out_gate #(
    .WIDTH (OUT_WIDTH)
  ) u_out_gate (
    .en   (key_loaded),
    .din  (core_out_in),
    .dout (core_out_gated)
  );

endmodule

// File: tb/tb_rll_key_sequencer.sv
// Self-checking bench for rll_key_sequencer: vector table, directed corner cases, randomized run vs model.
module tb_rll_key_sequencer;

  localparam int unsigned KW     = 32;
  localparam int unsigned WW     = 8;
  localparam int unsigned OW     = 32;
  localparam int unsigned SETTLE = 2;
  localparam int          NW     = KW / WW;

  localparam int M_IDLE = 0, M_FETCH = 1, M_SETTLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, relock, kw_valid, kw_last;
  logic [WW-1:0] kw_data;
`ifdef KEY_PARITY_CHECK_EN
  logic          kw_parity;
`endif
  logic          kw_ready, key_loaded, busy, err;
  logic [KW-1:0] key_out;
  logic [OW-1:0] core_out_in, core_out_gated;

  int n_chk = 0;
  int n_err = 0;

  int            m_mode;
  int            m_since;
  logic [KW-1:0] m_key;
  logic [WW-1:0] m_words[$];

  always #5 clk = ~clk;

  rll_key_sequencer #(
    .KEY_WIDTH     (KW),
    .WORD_WIDTH    (WW),
    .OUT_WIDTH     (OW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .relock         (relock),
    .kw_valid       (kw_valid),
    .kw_data        (kw_data),
    .kw_last        (kw_last),
`ifdef KEY_PARITY_CHECK_EN
    .kw_parity      (kw_parity),
`endif
    .kw_ready       (kw_ready),
    .key_out        (key_out),
    .core_out_in    (core_out_in),
    .core_out_gated (core_out_gated),
    .key_loaded     (key_loaded),
    .busy           (busy),
    .err            (err)
  );

  typedef struct {
    logic          start;
    logic          relock;
    logic          valid;
    logic [WW-1:0] data;
    logic          last;
    logic [KW-1:0] key;
    logic          ready;
    logic          busy;
    logic          loaded;
    logic          err;
  } vec_t;

  vec_t tv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_since = 0;
    m_key   = '0;
    m_words.delete();
  endtask

  // Abstract model: collect words in a queue, apply the key when the last one lands.
  task automatic model_edge();
    logic bad;
    logic [KW-1:0] k;
    if (relock) begin
      m_mode = M_IDLE;
      m_key  = '0;
      m_words.delete();
    end else begin
      case (m_mode)
        M_IDLE, M_ACTIVE, M_ERROR: begin
          if (start) begin
            m_mode = M_FETCH;
            m_words.delete();
          end
        end
        M_FETCH: begin
          if (kw_valid) begin
            m_words.push_back(kw_data);
            bad = (kw_last != (m_words.size() == NW));
`ifdef KEY_PARITY_CHECK_EN
            if (kw_parity != (^kw_data)) bad = 1'b1;
`endif
            if (bad) begin
              m_mode = M_ERROR;
              m_key  = '0;
              m_words.delete();
            end else if (kw_last) begin
              k = '0;
              for (int i = 0; i < NW; i++) k = k | (KW'(m_words[i]) << (WW * i));
              m_key   = k;
              m_mode  = M_SETTLE;
              m_since = 0;
            end
          end
        end
        M_SETTLE: begin
          m_since++;
          if (m_since == SETTLE) m_mode = M_ACTIVE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic exp_loaded;
    exp_loaded = (m_mode == M_ACTIVE);
    check("key_out", key_out, m_key);
    check("kw_ready", 32'(kw_ready), 32'(m_mode == M_FETCH));
    check("busy", 32'(busy), 32'(m_mode == M_FETCH || m_mode == M_SETTLE));
    check("key_loaded", 32'(key_loaded), 32'(exp_loaded));
    check("err", 32'(err), 32'(m_mode == M_ERROR));
    check("core_out_gated", core_out_gated, exp_loaded ? core_out_in : 32'h0);
  endtask

  task automatic cycle();
    core_out_in = $urandom;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    relock   = 1'b0;
    kw_valid = 1'b0;
    kw_data  = '0;
    kw_last  = 1'b0;
`ifdef KEY_PARITY_CHECK_EN
    kw_parity = 1'b0;
`endif
  endtask

  task automatic drive_word(input logic [WW-1:0] d, input logic last);
    kw_valid = 1'b1;
    kw_data  = d;
    kw_last  = last;
`ifdef KEY_PARITY_CHECK_EN
    kw_parity = ^d;
`endif
  endtask

  task automatic pulse_start();
    idle_inputs();
    start = 1'b1;
    cycle();
    idle_inputs();
  endtask

  task automatic load_key(input logic [KW-1:0] k);
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      drive_word(k[i*WW +: WW], i == NW - 1);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < SETTLE + 1; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [WW-1:0] words[4];
    int            vi;
    logic          vpat[7];

    idle_inputs();
    core_out_in = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    model_reset();
    #3;
    check("reset key_out", key_out, 32'h0);
    check("reset flags", {28'h0, kw_ready, key_loaded, busy, err}, 32'h0);
    check("reset gated", core_out_gated, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: nominal load as constant vectors.
    tv[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 32'h44332211, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h44332211, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      start  = tv[i].start;
      relock = tv[i].relock;
      if (tv[i].valid) drive_word(tv[i].data, tv[i].last);
      cycle();
      check($sformatf("tv%0d key", i), key_out, tv[i].key);
      check($sformatf("tv%0d flags", i), {28'h0, kw_ready, busy, key_loaded, err},
            {28'h0, tv[i].ready, tv[i].busy, tv[i].loaded, tv[i].err});
    end
    check("t1 gated tracks", core_out_gated, core_out_in);

    // Test 2: backpressure gaps after clearing the key.
    idle_inputs();
    relock = 1'b1;
    cycle();
    pulse_start();
    words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    vpat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vi = 0;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      if (vpat[i]) begin
        drive_word(words[vi], vi == NW - 1);
        vi++;
      end
      cycle();
      if (vi < NW) check("t2 key held zero", key_out, 32'h0);
    end
    check("t2 key", key_out, 32'hD4C3B2A1);
    idle_inputs();
    for (int i = 0; i < SETTLE; i++) cycle();
    check("t2 loaded", 32'(key_loaded), 32'h1);

    // Test 3: early kw_last on word 2, then recover.
    pulse_start();
    drive_word(8'h01, 1'b0);
    cycle();
    drive_word(8'h02, 1'b1);
    cycle();
    idle_inputs();
    check("t3 err", 32'(err), 32'h1);
    check("t3 key cleared", key_out, 32'h0);
    check("t3 gated", core_out_gated, 32'h0);
    pulse_start();
    check("t3 err cleared", 32'(err), 32'h0);
    for (int i = 0; i < NW; i++) begin
      drive_word(8'(8'h50 + i), i == NW - 1);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < SETTLE; i++) cycle();
    check("t3 reload key", key_out, 32'h53525150);
    check("t3 reload loaded", 32'(key_loaded), 32'h1);

    // Test 4: relock with the last-word handshake.
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      drive_word(8'(8'h60 + i), i == NW - 1);
      if (i == NW - 1) relock = 1'b1;
      cycle();
    end
    idle_inputs();
    check("t4 key", key_out, 32'h0);
    check("t4 idle", {28'h0, kw_ready, busy, key_loaded, err}, 32'h0);
    for (int i = 0; i < SETTLE + 2; i++) begin
      cycle();
      check("t4 never loaded", 32'(key_loaded), 32'h0);
    end

    // Test 5: reload from ACTIVE keeps the old key until the new one completes.
    load_key(32'h12345678);
    check("t5 first key", key_out, 32'h12345678);
    pulse_start();
    check("t5 loaded dropped", 32'(key_loaded), 32'h0);
    words = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < NW; i++) begin
      drive_word(words[i], i == NW - 1);
      cycle();
      if (i < NW - 1) check("t5 old key held", key_out, 32'h12345678);
      check("t5 not loaded", 32'(key_loaded), 32'h0);
    end
    idle_inputs();
    check("t5 new key", key_out, 32'hDEADBEEF);

    // Test 6: asynchronous reset mid-fetch.
    pulse_start();
    drive_word(8'h0A, 1'b0);
    cycle();
    drive_word(8'h0B, 1'b0);
    cycle();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6 key", key_out, 32'h0);
    check("t6 flags", {28'h0, kw_ready, busy, key_loaded, err}, 32'h0);
    check("t6 gated", core_out_gated, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

`ifdef KEY_PARITY_CHECK_EN
    pulse_start();
    drive_word(8'h03, 1'b0);
    cycle();
    drive_word(8'h05, 1'b0);
    cycle();
    drive_word(8'h07, 1'b0);
    kw_parity = ~(^kw_data);
    cycle();
    idle_inputs();
    check("t6 parity err", 32'(err), 32'h1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      start    = ($urandom_range(7) == 0);
      relock   = ($urandom_range(31) == 0);
      kw_valid = $urandom_range(1);
      kw_data  = 8'($urandom);
      kw_last  = (m_words.size() == NW - 1);
      if ($urandom_range(15) == 0) kw_last = ~kw_last;
`ifdef KEY_PARITY_CHECK_EN
      kw_parity = ^kw_data;
      if ($urandom_range(31) == 0) kw_parity = ~kw_parity;
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
